// File: rtl/uproc_ctrl.sv
// uproc_ctrl: 3-cycle fetch/decode/execute sequencer
// driving the 8-bit ALU + accumulator/carry datapath.
module uproc_ctrl #(
  parameter int PC_WIDTH = 8,
  parameter int IW = 12
) (
  input  logic                clk,
  input  logic                Reset,
  output logic [PC_WIDTH-1:0] PAddr,
  input  logic [IW-1:0]       Instr,
  input  logic [7:0]          A,
  input  logic                CY,
  output logic [2:0]          ALUCode,
  output logic [7:0]          R,
  output logic                A_CE,
  output logic                CY_CE,
  output logic                Halted
);

  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_NOT = 3'd6;
  localparam logic [2:0] ALU_LD  = 3'd7;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [IW-1:0]       ir;

  logic [3:0]          op;
  logic [PC_WIDTH-1:0] tgt;
  logic                is_alu;
  logic                is_arith;

  assign op       = ir[IW-1:IW-4];
  assign tgt      = PC_WIDTH'(ir[7:0]);
  assign is_alu   = (op != 4'h0) && !op[3];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);

  assign PAddr  = pc;
  assign R      = ir[7:0];
  assign Halted = (state == S_HALT);

  // ALU operation straight from IR; non-ALU opcodes park on LD
  always_comb begin
    ALUCode = ALU_LD;
    case (op)
      OP_ADD:  ALUCode = ALU_ADD;
      OP_SUB:  ALUCode = ALU_SUB;
      OP_AND:  ALUCode = ALU_AND;
      OP_OR:   ALUCode = ALU_OR;
      OP_XOR:  ALUCode = ALU_XOR;
      OP_NOT:  ALUCode = ALU_NOT;
      OP_LD:   ALUCode = ALU_LD;
      default: ALUCode = ALU_LD;
    endcase
  end

  // next state, next PC and datapath enables
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    A_CE      = 1'b0;
    CY_CE     = 1'b0;
    unique case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        pc_nxt    = pc + 1'b1;
        unique case (1'b1)
          is_alu: begin
            A_CE  = 1'b1;
            CY_CE = is_arith;
          end
          (op == OP_JMP): pc_nxt = tgt;
          (op == OP_JC): begin
            if (CY) pc_nxt = tgt;
          end
          (op == OP_JZ): begin
            if (A == 8'h00) pc_nxt = tgt;
          end
          (op == OP_HALT): begin
            pc_nxt    = pc;
            state_nxt = S_HALT;
          end
          default: ;
        endcase
      end
      S_HALT: ;
      default: state_nxt = S_FETCH;
    endcase
  end

  // state, PC and instruction register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_DECODE) ir <= Instr;
    end
  end

endmodule

// File: tb/tb_uproc_ctrl.sv
// tb_uproc_ctrl: directed + random programs run on a
// bench-side ROM/ALU/accumulator against an ISA-level model.
module tb_uproc_ctrl;

  localparam logic [2:0] ADD = 3'd1;
  localparam logic [2:0] SUB = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] OR  = 3'd4;
  localparam logic [2:0] XOR = 3'd5;
  localparam logic [2:0] NOT = 3'd6;
  localparam logic [2:0] LD  = 3'd7;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        dp_rst = 1'b1;
  logic [7:0]  PAddr;
  logic [11:0] Instr;
  logic [7:0]  A;
  logic        CY;
  logic [2:0]  ALUCode;
  logic [7:0]  R;
  logic        A_CE;
  logic        CY_CE;
  logic        Halted;
  logic [8:0]  alu_y;

  logic [11:0] rom [256];

  int checks = 0;
  int errors = 0;

  int m_pc;
  int m_a;
  int m_cy;
  bit m_halt;

  uproc_ctrl #(.PC_WIDTH(8), .IW(12)) dut (
    .clk(clk),
    .Reset(Reset),
    .PAddr(PAddr),
    .Instr(Instr),
    .A(A),
    .CY(CY),
    .ALUCode(ALUCode),
    .R(R),
    .A_CE(A_CE),
    .CY_CE(CY_CE),
    .Halted(Halted)
  );

  always #5 clk = ~clk;

  // synchronous program ROM, one cycle latency
  always @(posedge clk) Instr <= rom[PAddr];

  // ALU driven by the controller
  always_comb begin
    alu_y = {1'b0, A};
    case (ALUCode)
      ADD: alu_y = {1'b0, A} + {1'b0, R};
      SUB: alu_y = {1'b0, A} - {1'b0, R};
      AND: alu_y = {1'b0, A & R};
      OR:  alu_y = {1'b0, A | R};
      XOR: alu_y = {1'b0, A ^ R};
      NOT: alu_y = {1'b0, ~A};
      LD:  alu_y = {1'b0, R};
      default: alu_y = {1'b0, A};
    endcase
  end

  // accumulator and carry registers
  always @(posedge clk or posedge dp_rst) begin
    if (dp_rst) begin
      A  <= 8'h00;
      CY <= 1'b0;
    end else begin
      if (A_CE) A <= alu_y[7:0];
      if (CY_CE) CY <= alu_y[8];
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 12'h000;
  endtask

  // reset pulse; returns at a falling edge inside the first FETCH
  task automatic start(input bit keep_dp);
    Reset = 1'b1;
    if (!keep_dp) dp_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    Reset  = 1'b0;
    dp_rst = 1'b0;
    m_pc   = 0;
    m_halt = 1'b0;
    if (!keep_dp) begin
      m_a  = 0;
      m_cy = 0;
    end
  endtask

  // one instruction: checks all three cycles, then advances the model
  task automatic step();
    logic [11:0] w;
    int op;
    int r;
    int s;
    int nxt;
    logic [2:0] e_alu;
    w  = rom[m_pc];
    op = int'(w[11:8]);
    r  = int'(w[7:0]);
    #1;
    chk("fetch_paddr", 32'(PAddr), 32'(m_pc));
    chk("fetch_ace", 32'(A_CE), 0);
    chk("fetch_halted", 32'(Halted), 0);
    @(negedge clk);
    chk("dec_ace", 32'(A_CE), 0);
    chk("dec_cyce", 32'(CY_CE), 0);
    chk("dec_paddr", 32'(PAddr), 32'(m_pc));
    @(negedge clk);
    case (op)
      1: e_alu = ADD;
      2: e_alu = SUB;
      3: e_alu = AND;
      4: e_alu = OR;
      5: e_alu = XOR;
      6: e_alu = NOT;
      default: e_alu = LD;
    endcase
    chk("ex_ace", 32'(A_CE), (op >= 1 && op <= 7) ? 1 : 0);
    chk("ex_cyce", 32'(CY_CE), (op == 1 || op == 2) ? 1 : 0);
    chk("ex_alucode", 32'(ALUCode), 32'(e_alu));
    chk("ex_r", 32'(R), r);
    chk("ex_a", 32'(A), m_a);
    chk("ex_cy", 32'(CY), m_cy);
    nxt = (m_pc + 1) % 256;
    case (op)
      1: begin
        s = m_a + r;
        m_cy = (s > 255) ? 1 : 0;
        m_a = s % 256;
      end
      2: begin
        s = m_a - r;
        m_cy = (s < 0) ? 1 : 0;
        m_a = (s + 256) % 256;
      end
      3: m_a = m_a & r;
      4: m_a = m_a | r;
      5: m_a = m_a ^ r;
      6: m_a = 255 - m_a;
      7: m_a = r;
      8: nxt = r;
      9: if (m_cy == 1) nxt = r;
      10: if (m_a == 0) nxt = r;
      11: begin
        nxt = m_pc;
        m_halt = 1'b1;
      end
      default: ;
    endcase
    m_pc = nxt;
    @(negedge clk);
    if (m_halt) begin
      chk("halt_flag", 32'(Halted), 1);
      chk("halt_paddr", 32'(PAddr), 32'(m_pc));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n && !m_halt; k++) step();
  endtask

  initial begin
    // reset state
    clear_rom();
    #3;
    chk("rst_paddr", 32'(PAddr), 0);
    chk("rst_ace", 32'(A_CE), 0);
    chk("rst_cyce", 32'(CY_CE), 0);
    chk("rst_halted", 32'(Halted), 0);
    chk("rst_r", 32'(R), 0);
    chk("rst_alucode", 32'(ALUCode), 32'(LD));

    // basic LD / ADD sequence
    clear_rom();
    rom[0] = 12'h705;
    rom[1] = 12'h103;
    start(1'b0);
    run(2);
    chk("basic_paddr", 32'(PAddr), 2);
    chk("basic_a", 32'(A), 8);

    // carry jump taken
    clear_rom();
    rom[0] = 12'h7FF;
    rom[1] = 12'h102;
    rom[2] = 12'h940;
    start(1'b0);
    run(3);
    chk("jc_taken", 32'(PAddr), 32'h40);

    // carry jump not taken
    rom[0] = 12'h701;
    start(1'b0);
    run(3);
    chk("jc_untaken", 32'(PAddr), 32'h03);

    // zero jump taken / not taken
    clear_rom();
    rom[0] = 12'h700;
    rom[1] = 12'hA20;
    start(1'b0);
    run(2);
    chk("jz_taken", 32'(PAddr), 32'h20);
    rom[0] = 12'h701;
    start(1'b0);
    run(2);
    chk("jz_untaken", 32'(PAddr), 32'h02);

    // PC wrap 0xFF -> 0x00
    clear_rom();
    rom[0] = 12'h8FF;
    start(1'b0);
    run(2);
    chk("wrap_paddr", 32'(PAddr), 0);

    // halt is absorbing
    clear_rom();
    rom[0] = 12'h701;
    rom[1] = 12'h000;
    rom[2] = 12'hB00;
    start(1'b0);
    run(3);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("halt_hold", 32'(Halted), 1);
      chk("halt_pc", 32'(PAddr), 2);
      chk("halt_ace", 32'(A_CE), 0);
      chk("halt_cyce", 32'(CY_CE), 0);
    end
    Reset = 1'b1;
    #2;
    chk("halt_rst_flag", 32'(Halted), 0);
    chk("halt_rst_pc", 32'(PAddr), 0);
    start(1'b1);
    run(1);

    // reset in the middle of an EXECUTE
    clear_rom();
    rom[0] = 12'h705;
    rom[1] = 12'h105;
    start(1'b0);
    run(1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("mid_pre_ace", 32'(A_CE), 1);
    Reset = 1'b1;
    #1;
    chk("mid_ace", 32'(A_CE), 0);
    chk("mid_cyce", 32'(CY_CE), 0);
    chk("mid_paddr", 32'(PAddr), 0);
    chk("mid_r", 32'(R), 0);
    chk("mid_alucode", 32'(ALUCode), 32'(LD));
    @(posedge clk);
    #1;
    chk("mid_a_hold", 32'(A), 5);
    start(1'b1);
    run(2);
    chk("mid_a_after", 32'(A), 10);

    // random programs
    for (int t = 0; t < 8; t++) begin
      clear_rom();
      for (int i = 0; i < 32; i++) begin
        rom[i][11:8] = 4'($urandom_range(0, 15));
        rom[i][7:0]  = 8'($urandom_range(0, 39));
      end
      start(1'b0);
      run(40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
